// File: rtl/out_writeback.sv
// out_writeback - MVU write-back engine: skid FIFO from the quantizer, nested-stride address generation, data bank writes.
// Optional OUT_WRITEBACK_STALLCNT_EN adds a saturating stall_cnt output counting ungranted write cycles.
module out_writeback #(
   parameter int N       = 64,
   parameter int BDBANKA = 15,
   parameter int BPREC   = 6,
   parameter int BLENGTH = 15,
   parameter int DEPTH   = 4
) (
   input  logic               clk,
   input  logic               clr,
   input  logic               start,
   input  logic [BPREC-1:0]   oprecision,
   input  logic [BDBANKA-1:0] obaseaddr,
   input  logic [BDBANKA-1:0] ostride0,
   input  logic [BDBANKA-1:0] ostride1,
   input  logic [BDBANKA-1:0] ostride2,
   input  logic [BLENGTH-1:0] olength0,
   input  logic [BLENGTH-1:0] olength1,
   input  logic [BLENGTH-1:0] olength2,
   input  logic               in_valid,
   input  logic [N-1:0]       in_word,
   output logic               in_ready,
   output logic               wrd_en,
   input  logic               wrd_grnt,
   output logic [BDBANKA-1:0] wrd_addr,
   output logic [N-1:0]       wrd_word,
   output logic               busy,
   output logic               done
`ifdef OUT_WRITEBACK_STALLCNT_EN
   ,
   output logic [15:0]        stall_cnt
`endif
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   state_t r_state, w_next;

   logic [BPREC-1:0]   r_prec;
   logic [BDBANKA-1:0] r_s0, r_s1, r_s2, r_vaddr, r_waddr;
   logic [BLENGTH-1:0] r_l0, r_l1, r_l2;
   logic [BPREC-1:0]   r_wplane, r_iplane;
   logic [BLENGTH-1:0] r_wc0, r_wc1, r_wc2, r_ic0, r_ic1, r_ic2;
   logic               r_in_last;
   logic [N-1:0]       r_mem [DEPTH];
   logic [AW-1:0]      r_rd, r_wr;
   logic [AW:0]        r_count;

   logic               w_busy, w_wrd_en, w_in_ready, w_push, w_pop;
   logic [BPREC-1:0]   w_prec_m1;
   logic               w_wplane_end, w_wvec_last, w_iplane_end, w_ivec_last;
   logic [BLENGTH-1:0] w_wc0_n, w_wc1_n, w_wc2_n, w_ic0_n, w_ic1_n, w_ic2_n;
   logic [BDBANKA-1:0] w_vaddr_n;

   assign w_busy       = (r_state == S_RUN);
   assign w_wrd_en     = w_busy && (r_count != '0);
   assign w_in_ready   = w_busy && (r_count != (AW+1)'(DEPTH)) && !r_in_last;
   assign w_push       = in_valid && w_in_ready;
   assign w_pop        = w_wrd_en && wrd_grnt;
   assign w_prec_m1    = r_prec - 1'b1;
   assign w_wplane_end = (r_wplane == w_prec_m1);
   assign w_wvec_last  = (r_wc0 == r_l0) && (r_wc1 == r_l1) && (r_wc2 == r_l2);
   assign w_iplane_end = (r_iplane == w_prec_m1);
   assign w_ivec_last  = (r_ic0 == r_l0) && (r_ic1 == r_l1) && (r_ic2 == r_l2);

   // Vector step on plane wrap; write side also moves the vector base address.
   always_comb begin
      w_wc0_n   = r_wc0;
      w_wc1_n   = r_wc1;
      w_wc2_n   = r_wc2;
      w_vaddr_n = r_vaddr;
      if (r_wc0 != r_l0) begin
         w_wc0_n   = r_wc0 + 1'b1;
         w_vaddr_n = r_vaddr + r_s0;
      end else if (r_wc1 != r_l1) begin
         w_wc0_n   = '0;
         w_wc1_n   = r_wc1 + 1'b1;
         w_vaddr_n = r_vaddr + r_s1;
      end else if (r_wc2 != r_l2) begin
         w_wc0_n   = '0;
         w_wc1_n   = '0;
         w_wc2_n   = r_wc2 + 1'b1;
         w_vaddr_n = r_vaddr + r_s2;
      end
   end

   always_comb begin
      w_ic0_n = r_ic0;
      w_ic1_n = r_ic1;
      w_ic2_n = r_ic2;
      if (r_ic0 != r_l0) begin
         w_ic0_n = r_ic0 + 1'b1;
      end else if (r_ic1 != r_l1) begin
         w_ic0_n = '0;
         w_ic1_n = r_ic1 + 1'b1;
      end else if (r_ic2 != r_l2) begin
         w_ic0_n = '0;
         w_ic1_n = '0;
         w_ic2_n = r_ic2 + 1'b1;
      end
   end

   always_comb begin
      w_next = r_state;
      if (start) begin
         w_next = (oprecision == '0) ? S_DONE : S_RUN;
      end else begin
         case (r_state)
            S_RUN:   if (w_pop && w_wplane_end && w_wvec_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (clr) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (!clr && !start && w_push) r_mem[r_wr] <= in_word;
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         r_prec <= '0; r_s0 <= '0; r_s1 <= '0; r_s2 <= '0;
         r_l0 <= '0; r_l1 <= '0; r_l2 <= '0;
         r_vaddr <= '0; r_waddr <= '0; r_wplane <= '0; r_iplane <= '0;
         r_wc0 <= '0; r_wc1 <= '0; r_wc2 <= '0;
         r_ic0 <= '0; r_ic1 <= '0; r_ic2 <= '0;
         r_in_last <= 1'b0; r_rd <= '0; r_wr <= '0; r_count <= '0;
      end else if (start) begin
         // Restart also drops anything still queued from an aborted job.
         r_prec <= oprecision; r_s0 <= ostride0; r_s1 <= ostride1; r_s2 <= ostride2;
         r_l0 <= olength0; r_l1 <= olength1; r_l2 <= olength2;
         r_vaddr <= obaseaddr; r_waddr <= obaseaddr; r_wplane <= '0; r_iplane <= '0;
         r_wc0 <= '0; r_wc1 <= '0; r_wc2 <= '0;
         r_ic0 <= '0; r_ic1 <= '0; r_ic2 <= '0;
         r_in_last <= 1'b0; r_rd <= '0; r_wr <= '0; r_count <= '0;
      end else begin
         if (w_push) begin
            r_wr <= r_wr + 1'b1;
            if (w_iplane_end) begin
               r_iplane <= '0;
               r_ic0 <= w_ic0_n; r_ic1 <= w_ic1_n; r_ic2 <= w_ic2_n;
               if (w_ivec_last) r_in_last <= 1'b1;
            end else begin
               r_iplane <= r_iplane + 1'b1;
            end
         end
         if (w_pop) begin
            r_rd <= r_rd + 1'b1;
            if (w_wplane_end) begin
               r_wplane <= '0;
               r_wc0 <= w_wc0_n; r_wc1 <= w_wc1_n; r_wc2 <= w_wc2_n;
               r_vaddr <= w_vaddr_n;
               r_waddr <= w_vaddr_n;
            end else begin
               r_wplane <= r_wplane + 1'b1;
               r_waddr  <= r_waddr + 1'b1;
            end
         end
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
   end

`ifdef OUT_WRITEBACK_STALLCNT_EN
   logic [15:0] r_stall;
   always_ff @(posedge clk) begin
      if (clr || start)                                       r_stall <= '0;
      else if (w_wrd_en && !wrd_grnt && r_stall != 16'hFFFF)  r_stall <= r_stall + 1'b1;
   end
   assign stall_cnt = r_stall;
`endif

   assign in_ready = w_in_ready;
   assign wrd_en   = w_wrd_en;
   assign wrd_addr = r_waddr;
   assign wrd_word = w_wrd_en ? r_mem[r_rd] : '0;
   assign busy     = w_busy;
   assign done     = (r_state == S_DONE);
endmodule

// File: tb/tb_out_writeback.sv
// tb/tb_out_writeback.sv - scoreboard bench for out_writeback: directed jobs, monitor pops expected writes.
module tb_out_writeback;
   logic        clk = 1'b0;
   logic        clr, start, in_valid, wrd_grnt;
   logic [5:0]  oprecision;
   logic [14:0] obaseaddr, ostride0, ostride1, ostride2;
   logic [14:0] olength0, olength1, olength2;
   logic [63:0] in_word, wrd_word;
   logic        in_ready, wrd_en, busy, done;
   logic [14:0] wrd_addr;
`ifdef OUT_WRITEBACK_STALLCNT_EN
   logic [15:0] stall_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int done_cnt = 0;
   int stall_model = 0;
   logic skip_lat = 1'b0;
   logic [78:0] q [$];

   always #5 clk = ~clk;

   out_writeback dut (
      .clk(clk), .clr(clr), .start(start), .oprecision(oprecision),
      .obaseaddr(obaseaddr), .ostride0(ostride0), .ostride1(ostride1), .ostride2(ostride2),
      .olength0(olength0), .olength1(olength1), .olength2(olength2),
      .in_valid(in_valid), .in_word(in_word), .in_ready(in_ready),
      .wrd_en(wrd_en), .wrd_grnt(wrd_grnt), .wrd_addr(wrd_addr), .wrd_word(wrd_word),
      .busy(busy), .done(done)
`ifdef OUT_WRITEBACK_STALLCNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic monitor();
      logic [78:0] e;
      logic        ph = 1'b0;
      logic        pwr = 1'b0;
      logic [14:0] pa = '0;
      logic [63:0] pw = '0;
      forever begin
         @(negedge clk);
         if (!clr) begin
            if (ph) begin
               chk("hold_en", {63'd0, wrd_en}, 64'd1);
               chk("hold_addr", {49'd0, wrd_addr}, {49'd0, pa});
               chk("hold_word", wrd_word, pw);
            end
            if (wrd_en && wrd_grnt) begin
               if (q.size() == 0) begin
                  chk("unexpected_write_addr", {49'd0, wrd_addr}, 64'h7FFF_FFFF_FFFF_FFFF);
               end else begin
                  e = q.pop_front();
                  chk("write_addr", {49'd0, wrd_addr}, {49'd0, e[78:64]});
                  chk("write_word", wrd_word, e[63:0]);
               end
            end
            if (done) begin
               done_cnt++;
               if (!skip_lat) chk("done_after_last_write", {63'd0, pwr}, 64'd1);
            end
            if (wrd_en && !wrd_grnt) stall_model++;
         end
         ph  = wrd_en && !wrd_grnt && !start && !clr;
         pa  = wrd_addr;
         pw  = wrd_word;
         pwr = wrd_en && wrd_grnt;
      end
   endtask

   task automatic do_start(input logic [5:0] p, input logic [14:0] base,
                           input logic [14:0] s0, input logic [14:0] s1, input logic [14:0] s2,
                           input logic [14:0] l0, input logic [14:0] l1, input logic [14:0] l2);
      oprecision = p; obaseaddr = base;
      ostride0 = s0; ostride1 = s1; ostride2 = s2;
      olength0 = l0; olength1 = l1; olength2 = l2;
      q.delete();
      stall_model = 0;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic push(input logic [63:0] w, input logic [14:0] a);
      bit ok = 1'b0;
      q.push_back({a, w});
      in_valid = 1'b1;
      in_word  = w;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin ok = 1'b1; break; end
      end
      if (!ok) chk("push_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      bit ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) begin ok = 1'b1; break; end
      end
      chk("done_seen", {63'd0, ok}, 64'd1);
      @(posedge clk); #1;
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_busy"}, {63'd0, busy}, 64'd0);
      chk({nm, "_done"}, {63'd0, done}, 64'd0);
      chk({nm, "_wrd_en"}, {63'd0, wrd_en}, 64'd0);
      chk({nm, "_in_ready"}, {63'd0, in_ready}, 64'd0);
      chk({nm, "_wrd_addr"}, {49'd0, wrd_addr}, 64'd0);
      chk({nm, "_wrd_word"}, wrd_word, 64'd0);
   endtask

   initial begin
      clr = 1'b1; start = 1'b0; in_valid = 1'b0; wrd_grnt = 1'b0; in_word = '0;
      oprecision = '0; obaseaddr = '0; ostride0 = '0; ostride1 = '0; ostride2 = '0;
      olength0 = '0; olength1 = '0; olength2 = '0;
      fork
         monitor();
      join_none
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk); #1;
      clr = 1'b0;

      // basic: two planes, single vector
      wrd_grnt = 1'b1;
      do_start(6'd2, 15'h0100, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0);
      push(64'hAAAA_0000_0000_000A, 15'h0100);
      push(64'hBBBB_0000_0000_000B, 15'h0101);
      wait_done();

      // strides: 3x2 vectors of one plane
      do_start(6'd1, 15'h0000, 15'h0004, 15'h0010, 15'h0000, 15'h2, 15'h1, 15'h0);
      push(64'h1111_1111_1111_1111, 15'h0000);
      push(64'h2222_2222_2222_2222, 15'h0004);
      push(64'h3333_3333_3333_3333, 15'h0008);
      push(64'h4444_4444_4444_4444, 15'h0018);
      push(64'h5555_5555_5555_5555, 15'h001C);
      push(64'h6666_6666_6666_6666, 15'h0020);
      @(negedge clk);
      chk("last_taken_in_ready", {63'd0, in_ready}, 64'd0);
      chk("last_taken_busy", {63'd0, busy}, 64'd1);
      wait_done();
      in_valid = 1'b1; in_word = 64'hDEAD_BEEF_DEAD_BEEF;
      repeat (4) @(posedge clk);
      #1 in_valid = 1'b0;

      // backpressure: FIFO fills, head held stable while not granted
      wrd_grnt = 1'b0;
      do_start(6'd8, 15'h0040, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0);
      for (int i = 0; i < 4; i++) push(64'hC0DE_0000_0000_0000 + 64'(i), 15'h0040 + 15'(i));
      @(negedge clk);
      chk("full_in_ready", {63'd0, in_ready}, 64'd0);
      chk("full_wrd_en", {63'd0, wrd_en}, 64'd1);
      repeat (10) @(negedge clk);
      @(posedge clk); #1;
`ifdef OUT_WRITEBACK_STALLCNT_EN
      chk("stall_cnt", {48'd0, stall_cnt}, 64'(stall_model));
`endif
      wrd_grnt = 1'b1;
      for (int i = 4; i < 8; i++) push(64'hC0DE_0000_0000_0000 + 64'(i), 15'h0040 + 15'(i));
      wait_done();

      // address wrap at top of bank
      do_start(6'd2, 15'h7FFF, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0);
      push(64'h0123_4567_89AB_CDEF, 15'h7FFF);
      push(64'hFEDC_BA98_7654_3210, 15'h0000);
      wait_done();

      // zero precision: done without writes
      skip_lat = 1'b1;
      do_start(6'd0, 15'h0123, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0);
      @(negedge clk);
      chk("p0_done", {63'd0, done}, 64'd1);
      chk("p0_wrd_en", {63'd0, wrd_en}, 64'd0);
      @(negedge clk);
      chk("p0_done_low", {63'd0, done}, 64'd0);
      chk("p0_busy", {63'd0, busy}, 64'd0);
      @(posedge clk); #1;
      skip_lat = 1'b0;

      // restart after 3 of 8 writes
      done_cnt = 0;
      wrd_grnt = 1'b0;
      do_start(6'd8, 15'h0300, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0);
      for (int i = 0; i < 4; i++) push(64'h5EED_0000_0000_0000 + 64'(i), 15'h0300 + 15'(i));
      wrd_grnt = 1'b1;
      repeat (3) @(posedge clk);
      #1 wrd_grnt = 1'b0;
      do_start(6'd2, 15'h0200, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0);
      wrd_grnt = 1'b1;
      push(64'h0000_0000_0000_0200, 15'h0200);
      push(64'h0000_0000_0000_0201, 15'h0201);
      wait_done();
      repeat (3) @(posedge clk);
      #1 chk("restart_done_count", 64'(done_cnt), 64'd1);

      // clr mid-job
      wrd_grnt = 1'b0;
      do_start(6'd4, 15'h0500, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0, 15'h0);
      push(64'h0000_0000_0000_0500, 15'h0500);
      push(64'h0000_0000_0000_0501, 15'h0501);
      clr = 1'b1;
      q.delete();
      @(posedge clk); #1;
      clr = 1'b0;
      @(negedge clk);
      chk_all_zero("clr_mid");

      repeat (3) @(posedge clk);
      #1 chk("scoreboard_empty", 64'(q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
